// File: rtl/counter_pkg.sv
// Shared definitions for the wrapping up-counter: default width and the modular add used by the
// next-value logic.
package counter_pkg;

    localparam int unsigned COUNTER_DEFAULT_WIDTH = 4;

    // Wide enough for any WIDTH <= 32 plus one carry bit.
    typedef logic [32:0] wide_t;

    function automatic wide_t counter_wrap_add(wide_t value, wide_t step, wide_t modulus);
        wide_t sum;
        sum = value + step;
        if (sum >= modulus) begin
            sum = sum - modulus;
        end
        return sum;
    endfunction

endpackage

// File: rtl/counter.sv
// Free-running up-counter that advances by STEP every clock and wraps modulo MODULUS.
// Reset is synchronous and active-high.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH       = COUNTER_DEFAULT_WIDTH,
    parameter longint unsigned MODULUS     = 64'd1 << WIDTH,
    parameter longint unsigned RESET_VALUE = 64'd0,
    parameter longint unsigned STEP        = 64'd1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
        $error("counter: RESET_VALUE must be below MODULUS");
    end
    if (STEP < 1 || STEP >= MODULUS) begin : g_bad_step
        $error("counter: STEP must be in 1..MODULUS-1");
    end

    logic [WIDTH-1:0] count_q, count_d;

    // Sum is formed one bit wider than the count so non-power-of-two moduli wrap exactly.
    always_comb begin
        count_d = WIDTH'(counter_wrap_add(wide_t'(count_q), wide_t'(STEP), wide_t'(MODULUS)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= WIDTH'(RESET_VALUE);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed sequences on three configurations plus randomized
// reset pulses compared against a plain modular-arithmetic reference model.
module tb_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r0, r1, r2;
    logic [3:0] c0, c1, c2;

    int vectors = 0;
    int errors  = 0;

    // Reference model state: default, mod-10 step-3, reset-value-5.
    int m0, m1, m2;

    counter u_def (
        .clk   (clk),
        .reset (r0),
        .count (c0)
    );

    counter #(
        .WIDTH   (4),
        .MODULUS (10),
        .STEP    (3)
    ) u_mod (
        .clk   (clk),
        .reset (r1),
        .count (c1)
    );

    counter #(
        .RESET_VALUE (5)
    ) u_rv (
        .clk   (clk),
        .reset (r2),
        .count (c2)
    );

    // Advance the models using the resets the DUTs will sample, then step past the edge.
    task automatic tick();
        m0 = r0 ? 0 : (m0 + 1) % 16;
        m1 = r1 ? 0 : (m1 + 3) % 10;
        m2 = r2 ? 5 : (m2 + 1) % 16;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        r0 = 1'b1;
        r1 = 1'b1;
        r2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (c0 !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold_def edge %0d: got %0d want 0", i, c0);
            end
            vectors++;
            if (c1 !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold_mod edge %0d: got %0d want 0", i, c1);
            end
            vectors++;
            if (c2 !== 4'd5) begin
                errors++;
                $display("FAIL reset_hold_rv edge %0d: got %0d want 5", i, c2);
            end
        end
        r0 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (c0 !== 4'(i)) begin
                errors++;
                $display("FAIL reset_release edge %0d: got %0d want %0d", i, c0, i);
            end
        end
    endtask

    task automatic test_wrap();
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (c0 !== 4'((i + 1) % 16)) begin
                errors++;
                $display("FAIL wrap_seq step %0d: got %0d want %0d", i, c0, (i + 1) % 16);
            end
        end
    endtask

    task automatic test_mid_reset();
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        repeat (7) tick();
        vectors++;
        if (c0 !== 4'd7) begin
            errors++;
            $display("FAIL mid_reset_setup: got %0d want 7", c0);
        end
        r0 = 1'b1;
        tick();
        vectors++;
        if (c0 !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_apply: got %0d want 0", c0);
        end
        r0 = 1'b0;
        tick();
        vectors++;
        if (c0 !== 4'd1) begin
            errors++;
            $display("FAIL mid_reset_release: got %0d want 1", c0);
        end
    endtask

    task automatic test_wrap_reset();
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        repeat (15) tick();
        vectors++;
        if (c0 !== 4'd15) begin
            errors++;
            $display("FAIL wrap_reset_setup: got %0d want 15", c0);
        end
        r0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (c0 !== 4'd0) begin
                errors++;
                $display("FAIL wrap_reset_hold edge %0d: got %0d want 0", i, c0);
            end
        end
        r0 = 1'b0;
    endtask

    task automatic test_mod10();
        int exp_seq [7] = '{3, 6, 9, 2, 5, 8, 1};
        r1 = 1'b1;
        tick();
        r1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            vectors++;
            if (c1 !== 4'(exp_seq[i])) begin
                errors++;
                $display("FAIL mod10_seq step %0d: got %0d want %0d", i, c1, exp_seq[i]);
            end
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            vectors++;
            if (c1 >= 4'd10 || c1 !== 4'(m1)) begin
                errors++;
                $display("FAIL mod10_range step %0d: got %0d want %0d (<10)", i, c1, m1);
            end
        end
    endtask

    task automatic test_reset_value();
        r2 = 1'b1;
        tick();
        vectors++;
        if (c2 !== 4'd5) begin
            errors++;
            $display("FAIL rv_hold: got %0d want 5", c2);
        end
        r2 = 1'b0;
        for (int i = 6; i <= 7; i++) begin
            tick();
            vectors++;
            if (c2 !== 4'(i)) begin
                errors++;
                $display("FAIL rv_release: got %0d want %0d", c2, i);
            end
        end
    endtask

    task automatic test_random();
        int gap;
        int len;
        logic [2:0] sel;
        for (int p = 0; p < 1000; p++) begin
            r0 = 1'b0;
            r1 = 1'b0;
            r2 = 1'b0;
            gap = $urandom_range(0, 20);
            len = $urandom_range(1, 3);
            sel = 3'($urandom_range(1, 7));
            for (int k = 0; k < gap + len; k++) begin
                if (k == gap) {r0, r1, r2} = sel;
                tick();
                vectors++;
                if (c0 !== 4'(m0) || c1 !== 4'(m1) || c2 !== 4'(m2)) begin
                    errors++;
                    $display("FAIL random pulse %0d step %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                             p, k, c0, c1, c2, m0, m1, m2);
                end
            end
        end
        r0 = 1'b0;
        r1 = 1'b0;
        r2 = 1'b0;
    endtask

    initial begin
        m0 = 0;
        m1 = 0;
        m2 = 5;
        test_reset();
        test_wrap();
        test_mid_reset();
        test_wrap_reset();
        test_mod10();
        test_reset_value();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
